// File: rtl/serial_adder_fa.sv
// Bit-serial WIDTH-bit adder: one full adder built from half adders plus a registered carry loop.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.

module half_add (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module full_using_half_a (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;

  half_add u_ha0 (.x(a),  .y(b),  .s(s0), .c(c0));
  half_add u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

module serial_adder_fa #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] s_sr;
  logic [CW-1:0]    cnt;
  logic             c_reg;
  logic             s, c, last;
  logic [WIDTH-1:0] s_cat;

  full_using_half_a u_fa (.a(a_sr[0]), .b(b_sr[0]), .ci(c_reg), .s(s), .co(c));

  // New bit enters at the MSB; after WIDTH bits bit 0 has reached position 0.
  assign s_cat = {s, s_sr};
  assign last  = (cnt == CW'(WIDTH - 1));
  assign busy  = (state == ST_SHIFT);
  assign done  = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      s_sr    <= '0;
      c_reg   <= 1'b0;
      cnt     <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_SHIFT;
            a_sr  <= a_in;
            b_sr  <= b_in;
            c_reg <= cin;
            cnt   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          s_sr  <= s_cat[WIDTH-1:1];
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          c_reg <= c;
          cnt   <= cnt + CW'(1);
          if (last) begin
            state   <= ST_DONE;
            sum_out <= s_cat;
            cout    <= c;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // Carry into the MSB differs from carry out of it: two's-complement overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ovf <= 1'b0;
    else if ((state == ST_SHIFT) && last) ovf <= c_reg ^ c;
  end
`endif

endmodule

// File: tb/tb_serial_adder_fa.sv
// Directed bench for serial_adder_fa with a result scoreboard.
// Define SERIAL_ADD_OVF_EN to also check the overflow output.

module tb_serial_adder_fa;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum_out;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int   ntests = 0;
  int   nfail  = 0;
  exp_t q[$];
  logic [W-1:0] last_sum = '0;

  always #5 clk = ~clk;

  serial_adder_fa #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .sum_out(sum_out), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] full;
    exp_t e;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e.sum  = full[W-1:0];
    e.co   = full[W];
    e.ov   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    q.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    ntests++;
    if (q.size() == 0) begin
      nfail++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_sum"}, 32'(sum_out), 32'(e.sum));
      chk({tag, "_cout"}, 32'(cout), 32'(e.co));
`ifdef SERIAL_ADD_OVF_EN
      chk({tag, "_ovf"}, 32'(ovf), 32'(e.ov));
`endif
      last_sum = e.sum;
    end
  endtask

  // Drive one add, then time the busy window and the done latency.
  task automatic do_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci);
    int n, nb;
    @(negedge clk);
    a_in = a; b_in = b; cin = ci; start = 1'b1;
    push_exp(a, b, ci);
    @(negedge clk);
    start = 1'b0; a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
    n = 0; nb = 0;
    while (!done && n < 4 * W) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(W));
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(W));
    pop_chk(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, chg, nd;
    logic [W-1:0] ha [3];
    logic [W-1:0] hb [3];
    ha[0] = 8'h11; hb[0] = 8'h22;
    ha[1] = 8'hF0; hb[1] = 8'h0F;
    ha[2] = 8'hC3; hb[2] = 8'h81;

    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum_out), 0);
    chk("rst_cout", 32'(cout), 0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", 32'(ovf), 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_add("ff_01", 8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    do_add("3c_5a", 8'h3C, 8'h5A, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
    do_add("7f_01", 8'h7F, 8'h01, 1'b0);
    do_add("80_80", 8'h80, 8'h80, 1'b1);
`endif

    // Start held high: back-to-back ops, result register held between completions.
    @(negedge clk);
    a_in = ha[0]; b_in = hb[0]; cin = 1'b0; start = 1'b1;
    push_exp(ha[0], hb[0], 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n = 0; chg = 0;
      while (!done && n < 4 * W) begin
        if (sum_out !== last_sum) chg++;
        @(negedge clk);
        n++;
      end
      chk($sformatf("hold%0d_spacing", k), 32'(n + 1), 32'(W + 1));
      chk($sformatf("hold%0d_sum_stable", k), 32'(chg), 0);
      pop_chk($sformatf("hold%0d", k));
      if (k < 2) begin
        a_in = ha[k+1]; b_in = hb[k+1]; cin = 1'(k);
        push_exp(ha[k+1], hb[k+1], 1'(k));
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("hold_end_done", 32'(done), 0);

    // Start pulsed mid-SHIFT must be neither taken nor queued.
    @(negedge clk);
    a_in = 8'h25; b_in = 8'h13; cin = 1'b0; start = 1'b1;
    push_exp(8'h25, 8'h13, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a_in = 8'hAA; b_in = 8'h77; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    pop_chk("ignore");
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("ignore_not_queued", 32'(nd), 0);

    do_add("pre_rst", 8'h3C, 8'h5A, 1'b1);

    // Reset with cnt==4: the in-flight add is discarded.
    @(negedge clk);
    a_in = 8'h55; b_in = 8'h66; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_sum", 32'(sum_out), 0);
    chk("midrst_cout", 32'(cout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_sum = '0;
    do_add("post_rst", 8'h10, 8'h20, 1'b0);

    chk("sb_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
